sram_arbiter: RTL and testbench

//  Parametrised N-port arbiter/sequencer for the external async static RAM.

---
 rtl/sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_sram_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - N-port request/acknowledge arbiter and cycle sequencer for an async SRAM
//
// Purpose: grants one of NUM_PORTS requesters (fixed or round-robin priority)
// and runs one SRAM access IDLE -> SETUP -> STROBE (WAIT_STATES+1) -> HOLD.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req/we                    per-port request level and write flag
//   be/addr/wdata             per-port byte enables, word address, write data (packed)
//   ack                       one-cycle completion pulse for the owning port
//   rdata                     last completed read data
//   busy, gnt_id              access in progress, current owner
//   ram_cs_n/oe_n/we_n/be_n   SRAM strobes (active low)
//   ram_addr, ram_data        SRAM address and bidirectional data bus

module sram_arbiter #(
  parameter int NUM_PORTS   = 3,
  parameter int AW          = 18,
  parameter int DW          = 16,
  parameter int WAIT_STATES = 0,
  parameter int ARB_MODE    = 1,
  localparam int IDW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int BW         = DW / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    we,
  input  logic [NUM_PORTS*BW-1:0] be,
  input  logic [NUM_PORTS*AW-1:0] addr,
  input  logic [NUM_PORTS*DW-1:0] wdata,
  output logic [NUM_PORTS-1:0]    ack,
  output logic [DW-1:0]           rdata,
  output logic                    busy,
  output logic [IDW-1:0]          gnt_id,
  output logic                    ram_cs_n,
  output logic                    ram_oe_n,
  output logic                    ram_we_n,
  output logic [BW-1:0]           ram_be_n,
  output logic [AW-1:0]           ram_addr,
  inout  wire  [DW-1:0]           ram_data
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gnt_q, gnt_d;
  logic           we_q, we_d;
  logic [BW-1:0]  be_q, be_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]  rdata_q, rdata_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand;
  int             cand_w;

  // Winner search: round robin starts at the pointer, fixed mode at port 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    cand_w    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand_w = (ARB_MODE == 1) ? int'(ptr_q) + i : i;
      if (cand_w >= NUM_PORTS) cand_w = cand_w - NUM_PORTS;
      cand = IDW'(cand_w);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          // Snapshot the request so later requester changes cannot disturb the cycle.
          state_d = S_SETUP;
          gnt_d   = win_idx;
          ptr_d   = (win_idx == IDW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;
          we_d    = we[win_idx];
          be_d    = be[win_idx*BW +: BW];
          addr_d  = addr[win_idx*AW +: AW];
          wdata_d = wdata[win_idx*DW +: DW];
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CW'(WAIT_STATES);
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          if (!we_q) rdata_d = ram_data;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are decoded straight from the state register so an async reset
  // releases the bus without waiting for a clock edge.
  assign busy     = (state_q != S_IDLE);
  assign gnt_id   = gnt_q;
  assign rdata    = rdata_q;
  assign ram_cs_n = ~busy;
  assign ram_oe_n = ~(!we_q && (state_q == S_SETUP || state_q == S_STROBE));
  assign ram_we_n = ~(we_q && state_q == S_STROBE);
  assign ram_be_n = busy ? ~be_q : '1;
  assign ram_addr = addr_q;
  // Write data stays on the bus through HOLD for hold time; IDLE is the turnaround cycle.
  assign ram_data = (busy && we_q) ? wdata_q : {DW{1'bz}};

  always_comb begin
    ack = '0;
    if (state_q == S_HOLD) ack[gnt_q] = 1'b1;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - directed scoreboard bench for sram_arbiter
module tb_sram_arbiter;
  localparam int NP = 3;
  localparam int AW = 18;
  localparam int DW = 16;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: WS=0 round robin; dut1: WS=2 fixed priority
  logic [NP-1:0] req0, we0, ack0, req1, we1, ack1;
  logic [NP*BW-1:0] be0, be1;
  logic [NP*AW-1:0] addr0, addr1;
  logic [NP*DW-1:0] wdata0, wdata1;
  logic [DW-1:0] rdata0, rdata1;
  logic busy0, busy1, cs0, cs1, oe0, oe1, wen0, wen1;
  logic [1:0] gnt0, gnt1;
  logic [BW-1:0] ben0, ben1;
  logic [AW-1:0] raddr0, raddr1;
  wire [DW-1:0] ram_data0, ram_data1;
  logic [DW-1:0] m1;

  pullup pu0 (ram_data0);
  pullup pu1 (ram_data1);

  sram_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .WAIT_STATES(0), .ARB_MODE(1)) dut0 (
    .clk(clk), .rst(rst), .req(req0), .we(we0), .be(be0), .addr(addr0), .wdata(wdata0),
    .ack(ack0), .rdata(rdata0), .busy(busy0), .gnt_id(gnt0), .ram_cs_n(cs0), .ram_oe_n(oe0),
    .ram_we_n(wen0), .ram_be_n(ben0), .ram_addr(raddr0), .ram_data(ram_data0));

  sram_arbiter #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .WAIT_STATES(2), .ARB_MODE(0)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .we(we1), .be(be1), .addr(addr1), .wdata(wdata1),
    .ack(ack1), .rdata(rdata1), .busy(busy1), .gnt_id(gnt1), .ram_cs_n(cs1), .ram_oe_n(oe1),
    .ram_we_n(wen1), .ram_be_n(ben1), .ram_addr(raddr1), .ram_data(ram_data1));

  // SRAM models: dut0 returns an address-derived word, dut1 is one byte-writable word.
  function automatic logic [DW-1:0] model_word(input logic [AW-1:0] a);
    return (a[7:0] == 8'h23) ? 16'hA5C3 : {8'hC0, a[7:0]};
  endfunction
  assign ram_data0 = (!cs0 && !oe0) ? model_word(raddr0) : 16'hzzzz;
  assign ram_data1 = (!cs1 && !oe1) ? m1 : 16'hzzzz;
  always @(posedge clk or posedge rst) begin
    if (rst) m1 <= 16'hFFFF;
    else if (!cs1 && !wen1) begin
      if (!ben1[0]) m1[7:0]  <= ram_data1[7:0];
      if (!ben1[1]) m1[15:8] <= ram_data1[15:8];
    end
  end

  typedef struct { int port; bit rd; logic [DW-1:0] data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ack0 != '0) begin
      if (q0.size() == 0) check("sb0_unexpected_ack", 32'(ack0), 32'd0);
      else begin
        exp_t e;
        e = q0.pop_front();
        check("sb0_ack_port", 32'(ack0), 32'd1 << e.port);
        if (e.rd) check("sb0_rdata", 32'(rdata0), 32'(e.data));
      end
    end
    if (!rst && ack1 != '0) begin
      if (q1.size() == 0) check("sb1_unexpected_ack", 32'(ack1), 32'd0);
      else begin
        exp_t e;
        e = q1.pop_front();
        check("sb1_ack_port", 32'(ack1), 32'd1 << e.port);
        if (e.rd) check("sb1_rdata", 32'(rdata1), 32'(e.data));
      end
    end
  end

  task automatic wait_ack0(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack0 != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ack1(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (ack1 != '0) begin ok = 1'b1; break; end
    end
  endtask

  initial begin
    bit ok;
    int c0, last, wlow;
    rst = 1'b1;
    req0 = '0; we0 = '0; be0 = '1; addr0 = '0; wdata0 = '0;
    req1 = '0; we1 = '0; be1 = '1; addr1 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_ack", 32'(ack0), 32'd0);
    check("rst_rdata", 32'(rdata0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_gnt", 32'(gnt0), 32'd0);
    check("rst_strobes", {29'd0, cs0, oe0, wen0}, 32'd7);
    check("rst_be_n", 32'(ben0), 32'd3);
    check("rst_addr", 32'(raddr0), 32'd0);
    check("rst_bus_released", 32'(ram_data0), 32'hFFFF);

    // round robin, all ports requesting continuously
    @(posedge clk); #1;
    for (int p = 0; p < NP; p++) addr0[p*AW +: AW] = AW'(16 + p);
    req0 = 3'b111;
    c0 = cyc;
    for (int p = 0; p < 6; p++) q0.push_back('{p % 3, 1'b1, 16'hC010 + 16'(p % 3)});
    last = c0;
    for (int k = 0; k < 6; k++) begin
      wait_ack0(ok);
      check("rr_timeout", 32'(ok), 32'd1);
      if (k == 0) check("rr_latency", cyc - c0, 32'd3);
      else check("rr_spacing", cyc - last, 32'd4);
      check("rr_gnt_order", 32'(gnt0), 32'(k % 3));
      last = cyc;
    end
    req0 = '0;
    repeat (3) @(negedge clk);
    check("rr_no_repeat", 32'(busy0), 32'd0);

    // read, WS=0, port 1
    @(posedge clk); #1;
    addr0[AW +: AW] = 18'h00123;
    req0 = 3'b010;
    q0.push_back('{1, 1'b1, 16'hA5C3});
    @(negedge clk);
    check("rd_t_oe", 32'(oe0), 32'd1);
    @(negedge clk);
    check("rd_t1_oe", 32'(oe0), 32'd0);
    check("rd_t1_cs", 32'(cs0), 32'd0);
    check("rd_t1_addr", 32'(raddr0), 32'h123);
    check("rd_t1_gnt", 32'(gnt0), 32'd1);
    @(negedge clk);
    check("rd_t2_oe", 32'(oe0), 32'd0);
    check("rd_t2_ack", 32'(ack0), 32'd0);
    @(negedge clk);
    check("rd_t3_ack", 32'(ack0), 32'b010);
    check("rd_t3_oe", 32'(oe0), 32'd1);
    req0 = '0;
    @(negedge clk);
    check("rd_t4_cs", 32'(cs0), 32'd1);
    @(negedge clk);
    check("rd_no_repeat", 32'(busy0), 32'd0);

    // write, WS=2, port 0, byte lane 0 only
    @(posedge clk); #1;
    we1 = 3'b001; be1[1:0] = 2'b01; wdata1[15:0] = 16'h5A00; addr1[AW-1:0] = 18'h5;
    req1 = 3'b001;
    q1.push_back('{0, 1'b0, 16'h0});
    wlow = 0;
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (wen1 == 1'b0) wlow++;
      if (n == 1) begin
        check("wr_setup_be_n", 32'(ben1), 32'b10);
        check("wr_setup_oe", 32'(oe1), 32'd1);
        check("wr_setup_bus", 32'(ram_data1), 32'h5A00);
        // changes after grant must be ignored
        be1[1:0] = 2'b11; wdata1[15:0] = 16'h1111;
      end
      if (n == 5) begin
        check("wr_ack_cycle", 32'(ack1), 32'b001);
        check("wr_hold_bus", 32'(ram_data1), 32'h5A00);
        check("wr_hold_we", 32'(wen1), 32'd1);
        check("wr_rdata_kept", 32'(rdata1), 32'd0);
        req1 = '0;
      end
    end
    check("wr_we_low_cycles", 32'(wlow), 32'd3);
    check("wr_model_word", 32'(m1), 32'hFF00);

    // fixed priority: port 0 holds req, port 2 waits
    @(posedge clk); #1;
    we1 = '0; req1 = 3'b101;
    for (int p = 0; p < 3; p++) q1.push_back('{0, 1'b1, 16'hFF00});
    q1.push_back('{2, 1'b1, 16'hFF00});
    for (int k = 0; k < 4; k++) begin
      wait_ack1(ok);
      check("fx_timeout", 32'(ok), 32'd1);
      if (k == 2) req1[0] = 1'b0;
      if (k == 3) req1 = '0;
    end
    repeat (3) @(negedge clk);
    check("fx_idle", 32'(busy1), 32'd0);

    // reset during STROBE of a write
    @(posedge clk); #1;
    we0 = 3'b001; be0[1:0] = 2'b11; wdata0[15:0] = 16'h1234; req0 = 3'b001;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("ab_strobe_we", 32'(wen0), 32'd0);
    check("ab_strobe_bus", 32'(ram_data0), 32'h1234);
    rst = 1'b1;
    #1;
    check("ab_we_n", 32'(wen0), 32'd1);
    check("ab_cs_n", 32'(cs0), 32'd1);
    check("ab_oe_n", 32'(oe0), 32'd1);
    check("ab_bus_released", 32'(ram_data0), 32'hFFFF);
    check("ab_busy", 32'(busy0), 32'd0);
    check("ab_ack", 32'(ack0), 32'd0);
    check("ab_rdata", 32'(rdata0), 32'd0);
    check("ab_be_n", 32'(ben0), 32'd3);
    check("ab_addr", 32'(raddr0), 32'd0);
    we0 = '0; req0 = 3'b111;
    @(posedge clk); #1 rst = 1'b0;
    q0.push_back('{0, 1'b1, 16'hC010});
    wait_ack0(ok);
    check("ab_timeout", 32'(ok), 32'd1);
    req0 = '0;
    repeat (6) @(negedge clk);

    check("sb0_drained", 32'(q0.size()), 32'd0);
    check("sb1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
